b_g_counter: RTL and testbench



---
 rtl/gray_pkg.sv | 19 +
 rtl/b_g.sv | 11 +
 rtl/b_g_counter.sv | 70 +++++++
 tb/tb_b_g_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for the binary/Gray counter family.
// Helpers operate on a fixed wide vector; callers zero-extend and truncate with casts.
package gray_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction
endpackage

// File: rtl/b_g.sv
// Combinational binary-to-Gray converter; the mirror of the g_b decoder.
module b_g
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));
endmodule

// File: rtl/b_g_counter.sv
// Up/down binary counter with registered Gray output, wrap pulse and sticky
// single-bit-change error flag.
module b_g_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             wrap,
  output logic             err
);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] g_next;
  logic             step;
  logic             wrap_next;
  logic             err_next;

  always_comb begin
    b_next = b;
    step   = 1'b0;
    if (clr) begin
      b_next = '0;
    end else if (load) begin
      b_next = load_bin;
    end else if (en) begin
      step   = 1'b1;
      b_next = up ? b + WIDTH'(1) : b - WIDTH'(1);
    end
  end

  b_g #(.WIDTH(WIDTH)) u_b_g (
    .bin  (b_next),
    .gray (g_next)
  );

  // Only count steps are checked; clr/load jumps are allowed to change many bits.
  always_comb begin
    wrap_next = step && (up ? (b == ALL_ONES) : (b == '0));
    err_next  = err;
    if (clr) begin
      err_next = 1'b0;
    end else if (step && (popcount(MAX_WIDTH'(g_next ^ g)) != 1)) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b    <= '0;
      g    <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      b    <= b_next;
      g    <= g_next;
      wrap <= wrap_next;
      err  <= err_next;
    end
  end
endmodule

// File: tb/tb_b_g_counter.sv
// Directed and table-driven bench for b_g_counter.
module tb_b_g_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_bin = 4'd0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic [3:0] b;
  logic [3:0] g;
  logic       wrap;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  b_g_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_bin (load_bin),
    .en       (en),
    .up       (up),
    .b        (b),
    .g        (g),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] load_bin;
    logic       en;
    logic       up;
    logic [3:0] exp_b;
    logic [3:0] exp_g;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] sweep_g[17];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lb,
                       input logic e, input logic u);
    clr = c; load = l; load_bin = lb; en = e; up = u;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] decode(input logic [3:0] gv);
    logic [3:0] r;
    r[3] = gv[3];
    for (int i = 2; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
    return r;
  endfunction

  initial begin
    logic [3:0] prev_g;
    logic [3:0] m;
    logic       dir;

    //            clr   load  lb     en    up    b      g        wrap
    vecs[0]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'b0001, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd2,  4'b0011, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd10, 1'b1, 1'b1, 4'd10, 4'b1111, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 4'd0,  4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'b1000, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd15, 4'b1000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'b0000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 4'b1000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd15, 4'b1000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  4'b0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'b0001, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'b0000, 1'b0};

    sweep_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                4'b1000, 4'b0000, 4'b0001};

    // reset state
    #12;
    check("reset_b", int'(b), 0);
    check("reset_g", int'(g), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].load_bin, vecs[i].en, vecs[i].up);
      tick();
      check($sformatf("vec%0d_b", i), int'(b), int'(vecs[i].exp_b));
      check($sformatf("vec%0d_g", i), int'(g), int'(vecs[i].exp_g));
      check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_err", i), int'(err), 0);
    end

    // full up sweep from 0 (17 steps: wraps after 15 -> 0, then one more)
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      tick();
      check($sformatf("sweep%0d_g", i), int'(g), int'(sweep_g[i]));
      check($sformatf("sweep%0d_wrap", i), int'(wrap), (i == 15) ? 1 : 0);
    end
    check("sweep_err", int'(err), 0);

    // down wrap from 1
    drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    check("down0_b", int'(b), 0);
    check("down0_g", int'(g), 0);
    check("down0_wrap", int'(wrap), 0);
    tick();
    check("down1_b", int'(b), 15);
    check("down1_g", int'(g), 8);
    check("down1_wrap", int'(wrap), 1);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    check("down_hold_wrap", int'(wrap), 0);

    // direction reversal around 7/8
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    tick();
    check("rev_start_g", int'(g), 4'b0100);
    prev_g = g;
    for (int i = 0; i < 6; i++) begin
      dir = (i % 2 == 0);
      drive(1'b0, 1'b0, 4'd0, 1'b1, dir);
      tick();
      check($sformatf("rev%0d_b", i), int'(b), dir ? 8 : 7);
      check($sformatf("rev%0d_onebit", i), $countones(g ^ prev_g), 1);
      check($sformatf("rev%0d_wrap", i), int'(wrap), 0);
      prev_g = g;
    end

    // random round trip through a Gray decoder
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    m = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      clr      = 1'b0;
      load     = ($urandom_range(0, 9) == 0);
      load_bin = 4'($urandom_range(0, 15));
      en       = 1'($urandom_range(0, 1));
      up       = 1'($urandom_range(0, 1));
      if (load)    m = load_bin;
      else if (en) m = up ? m + 4'd1 : m - 4'd1;
      tick();
      check("rt_b", int'(b), int'(m));
      check("rt_decode", int'(decode(g)), int'(b));
    end
    check("rt_err", int'(err), 0);

    // asynchronous reset mid-count at b = 9
    drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    tick();
    check("pre_rst_b", int'(b), 9);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_b", int'(b), 0);
    check("async_rst_g", int'(g), 0);
    check("async_rst_wrap", int'(wrap), 0);
    check("async_rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    tick();
    tick();
    check("post_rst_b", int'(b), 0);
    check("post_rst_g", int'(g), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
